// File: rtl/nxn_game_pkg.sv
// Shared types for the N x N, K-in-a-row game controller.
// Holds the cell and winner encodings, the controller state enum and the
// line-direction enum together with the (row, column) step for each direction.
package nxn_game_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b01,
        CELL_O     = 2'b10
    } cell_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OVER  = 2'd2
    } state_e;

    // Checked in this order, one per cycle.
    typedef enum logic [1:0] {
        DIR_H = 2'd0,   // horizontal     (0, +1)
        DIR_V = 2'd1,   // vertical       (+1, 0)
        DIR_D = 2'd2,   // diagonal       (+1, +1)
        DIR_A = 2'd3    // anti-diagonal  (+1, -1)
    } dir_e;

    function automatic int dir_dr(dir_e d);
        return (d == DIR_H) ? 0 : 1;
    endfunction

    function automatic int dir_dc(dir_e d);
        case (d)
            DIR_H:   return 1;
            DIR_V:   return 0;
            DIR_D:   return 1;
            default: return -1;
        endcase
    endfunction

endpackage

// File: rtl/line_run_counter.sv
// Combinational run-length counter along one line through a board cell.
// Counts the cell itself plus consecutive cells holding the same mark in the
// forward and backward direction, each side limited to K-1 steps and stopped
// by the board edge or the first non-matching cell.
// Ports:
//   board_i  packed board, cell (r,c) at [2*(r*N+c)+:2]
//   row_i    row of the cell the line passes through
//   col_i    column of the cell the line passes through
//   dir_i    line direction (H, V, D, A)
//   mark_i   mark being counted (X or O)
//   run_o    run length, at most 2K-1
module line_run_counter
    import nxn_game_pkg::*;
#(
    parameter int N    = 3,
    parameter int K    = N,
    parameter int RW   = 2,
    parameter int RUNW = 3
) (
    input  logic [2*N*N-1:0] board_i,
    input  logic [RW-1:0]    row_i,
    input  logic [RW-1:0]    col_i,
    input  dir_e             dir_i,
    input  logic [1:0]       mark_i,
    output logic [RUNW-1:0]  run_o
);

    // Bit s: the cell s steps away (forward / backward) is on the board and matches.
    logic [K-1:1] fwd_hit;
    logic [K-1:1] bwd_hit;

    generate
        for (genvar gi = 1; gi < K; gi++) begin : g_step
            logic hit_f;
            logic hit_b;

            always_comb begin
                int rf;
                int cf;
                int rb;
                int cb;
                rf    = int'(row_i) + gi * dir_dr(dir_i);
                cf    = int'(col_i) + gi * dir_dc(dir_i);
                rb    = int'(row_i) - gi * dir_dr(dir_i);
                cb    = int'(col_i) - gi * dir_dc(dir_i);
                hit_f = 1'b0;
                hit_b = 1'b0;
                if (rf >= 0 && rf < N && cf >= 0 && cf < N)
                    hit_f = (board_i[2*(rf*N+cf) +: 2] == mark_i);
                if (rb >= 0 && rb < N && cb >= 0 && cb < N)
                    hit_b = (board_i[2*(rb*N+cb) +: 2] == mark_i);
            end

            assign fwd_hit[gi] = hit_f;
            assign bwd_hit[gi] = hit_b;
        end
    endgenerate

    // A side's run ends at the first miss, so later hits must not count.
    always_comb begin
        int   fwd;
        int   bwd;
        logic alive_f;
        logic alive_b;
        fwd     = 0;
        bwd     = 0;
        alive_f = 1'b1;
        alive_b = 1'b1;
        for (int s = 1; s < K; s++) begin
            alive_f = alive_f & fwd_hit[s];
            alive_b = alive_b & bwd_hit[s];
            if (alive_f) fwd++;
            if (alive_b) bwd++;
        end
        run_o = RUNW'(1 + fwd + bwd);
    end

endmodule

// File: rtl/nxn_game_ctrl.sv
// N x N, K-in-a-row board-game controller.
// Holds the board, accepts moves over a valid/ready handshake, rejects illegal
// moves with a one-cycle error pulse, and checks for a win through the last
// placed cell one direction per cycle (4 cycles). Reports turn, winner, draw.
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   new_game_i    synchronous clear, highest priority
//   move_valid_i  move offered
//   move_row_i    row index (0 = row A)
//   move_col_i    column index (0 = column 1)
//   move_ready_o  high in PLAY
//   move_err_o    one-cycle pulse after a rejected move
//   turn_o        player to move (0 = X, 1 = O)
//   game_over_o   high in OVER
//   winner_o      00 none, 01 X, 10 O, 11 draw
//   board_o       packed board, cell (r,c) at [2*(r*N+c)+:2]
module nxn_game_ctrl
    import nxn_game_pkg::*;
#(
    parameter int  N         = 3,
    parameter int  K         = N,
    parameter bit  ALT_START = 1'b0,
    localparam int RW        = (N > 2) ? $clog2(N) : 1,
    localparam int CW        = $clog2(N * N + 1),
    localparam int RUNW      = $clog2(2 * K)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             new_game_i,
    input  logic             move_valid_i,
    input  logic [RW-1:0]    move_row_i,
    input  logic [RW-1:0]    move_col_i,
    output logic             move_ready_o,
    output logic             move_err_o,
    output logic             turn_o,
    output logic             game_over_o,
    output logic [1:0]       winner_o,
    output logic [2*N*N-1:0] board_o
);

    state_e            state_q, state_d;
    logic [2*N*N-1:0]  board_q, board_d;
    logic              turn_q, turn_d;
    logic [1:0]        winner_q, winner_d;
    logic [CW-1:0]     count_q, count_d;
    logic [RW-1:0]     row_q, row_d;
    logic [RW-1:0]     col_q, col_d;
    dir_e              dir_q, dir_d;
    logic              win_q, win_d;
    logic              err_q, err_d;
    logic              start_q, start_d;

    logic [1:0]        mark;
    logic [RUNW-1:0]   run;
    logic              win_now;

    assign mark = turn_q ? CELL_O : CELL_X;

    line_run_counter #(
        .N    (N),
        .K    (K),
        .RW   (RW),
        .RUNW (RUNW)
    ) u_run (
        .board_i (board_q),
        .row_i   (row_q),
        .col_i   (col_q),
        .dir_i   (dir_q),
        .mark_i  (mark),
        .run_o   (run)
    );

    // Win flag is sticky across the four direction cycles.
    assign win_now = win_q | (int'(run) >= K);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_PLAY;
            board_q  <= '0;
            turn_q   <= 1'b0;
            winner_q <= WIN_NONE;
            count_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            dir_q    <= DIR_H;
            win_q    <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            turn_q   <= turn_d;
            winner_q <= winner_d;
            count_q  <= count_d;
            row_q    <= row_d;
            col_q    <= col_d;
            dir_q    <= dir_d;
            win_q    <= win_d;
            err_q    <= err_d;
            start_q  <= start_d;
        end
    end

    always_comb begin
        int idx;
        state_d  = state_q;
        board_d  = board_q;
        turn_d   = turn_q;
        winner_d = winner_q;
        count_d  = count_q;
        row_d    = row_q;
        col_d    = col_q;
        dir_d    = dir_q;
        win_d    = win_q;
        err_d    = 1'b0;
        start_d  = start_q;
        idx      = 2 * (int'(move_row_i) * N + int'(move_col_i));

        if (new_game_i) begin
            state_d  = ST_PLAY;
            board_d  = '0;
            count_d  = '0;
            winner_d = WIN_NONE;
            win_d    = 1'b0;
            dir_d    = DIR_H;
            if (ALT_START) begin
                start_d = ~start_q;
                turn_d  = ~start_q;
            end else begin
                turn_d  = 1'b0;
            end
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (move_valid_i) begin
                        err_d = 1'b1;
                        if (int'(move_row_i) < N && int'(move_col_i) < N) begin
                            if (board_q[idx +: 2] == CELL_EMPTY) begin
                                err_d            = 1'b0;
                                board_d[idx +: 2] = mark;
                                count_d          = count_q + CW'(1);
                                row_d            = move_row_i;
                                col_d            = move_col_i;
                                dir_d            = DIR_H;
                                win_d            = 1'b0;
                                state_d          = ST_CHECK;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    win_d = win_now;
                    if (dir_q == DIR_A) begin
                        // A win on the last free cell takes precedence over a draw.
                        if (win_now) begin
                            state_d  = ST_OVER;
                            winner_d = mark;
                        end else if (count_q == CW'(N * N)) begin
                            state_d  = ST_OVER;
                            winner_d = WIN_DRAW;
                        end else begin
                            turn_d   = ~turn_q;
                            state_d  = ST_PLAY;
                        end
                    end else begin
                        dir_d = dir_e'(dir_q + 2'd1);
                    end
                end
                default: begin
                    // OVER: moves are ignored until new_game.
                end
            endcase
        end
    end

    assign move_ready_o = (state_q == ST_PLAY);
    assign game_over_o  = (state_q == ST_OVER);
    assign move_err_o   = err_q;
    assign turn_o       = turn_q;
    assign winner_o     = winner_q;
    assign board_o      = board_q;

endmodule

// File: tb/tb_nxn_game_ctrl.sv
// Bench for nxn_game_ctrl with N=5, K=4, ALT_START=1.
// A driver issues scripted and random moves and keeps a rule-level model of
// the game; each expected DUT response (error pulse or check result) goes into
// a queue that a negedge monitor pops when the DUT shows that response.
module tb_nxn_game_ctrl;

    localparam int N  = 5;
    localparam int K  = 4;
    localparam int RW = 3;

    logic             clk;
    logic             rst_n;
    logic             new_game;
    logic             move_valid;
    logic [RW-1:0]    move_row;
    logic [RW-1:0]    move_col;
    logic             move_ready;
    logic             move_err;
    logic             turn;
    logic             game_over;
    logic [1:0]       winner;
    logic [2*N*N-1:0] board;

    nxn_game_ctrl #(
        .N         (N),
        .K         (K),
        .ALT_START (1'b1)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .new_game_i   (new_game),
        .move_valid_i (move_valid),
        .move_row_i   (move_row),
        .move_col_i   (move_col),
        .move_ready_o (move_ready),
        .move_err_o   (move_err),
        .turn_o       (turn),
        .game_over_o  (game_over),
        .winner_o     (winner),
        .board_o      (board)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(string msg);
        n_checks++;
        $display("FAIL %s", msg);
    endtask

    typedef struct {
        bit               is_err;
        logic [2*N*N-1:0] board;
        bit               turn;
        logic [1:0]       winner;
        bit               over;
        int               due;
    } exp_t;

    exp_t sbq[$];

    // ---------------- reference model ----------------
    int mb[N][N];       // 0 empty, 1 X, 2 O
    bit m_turn;
    bit m_start;
    int m_count;
    int m_winner;
    bit m_over;

    function automatic logic [2*N*N-1:0] model_bits();
        logic [2*N*N-1:0] b;
        b = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                b[2*(r*N+c) +: 2] = 2'(mb[r][c]);
        return b;
    endfunction

    // Any K consecutive cells of mark m along a row, column or diagonal.
    function automatic bit has_line(int m);
        int dr[4];
        int dc[4];
        dr = '{0, 1, 1, 1};
        dc = '{1, 0, 1, -1};
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                for (int d = 0; d < 4; d++) begin
                    bit ok;
                    ok = 1'b1;
                    for (int s = 0; s < K; s++) begin
                        int rr;
                        int cc;
                        rr = r + s * dr[d];
                        cc = c + s * dc[d];
                        if (rr < 0 || rr >= N || cc < 0 || cc >= N) ok = 1'b0;
                        else if (mb[rr][cc] != m) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mb[r][c] = 0;
        m_count  = 0;
        m_winner = 0;
        m_over   = 1'b0;
    endfunction

    // ---------------- monitor ----------------
    int ncount    = 0;
    bit prev_busy = 1'b0;

    always @(negedge clk) begin
        bit   busy;
        exp_t e;
        ncount++;
        busy = !move_ready && !game_over;
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (move_err) begin
                if (sbq.size() == 0) begin
                    fail("move_err pulse with no rejected move pending");
                end else begin
                    e = sbq.pop_front();
                    $display("[%0d] reject  board=%h turn=%0d", ncount, board, turn);
                    if (!e.is_err) fail("move_err pulse where a check result was expected");
                    check("err_time", 64'(ncount), 64'(e.due));
                    check("err_board", 64'(board), 64'(e.board));
                    check("err_turn", 64'(turn), 64'(e.turn));
                    check("err_ready", 64'(move_ready), 64'(1));
                end
            end
            if (prev_busy && !busy) begin
                if (sbq.size() == 0) begin
                    fail("check finished with no accepted move pending");
                end else begin
                    e = sbq.pop_front();
                    $display("[%0d] result  board=%h turn=%0d winner=%0d over=%0d",
                             ncount, board, turn, winner, game_over);
                    if (e.is_err) fail("check result where a move_err pulse was expected");
                    check("res_time", 64'(ncount), 64'(e.due));
                    check("res_board", 64'(board), 64'(e.board));
                    check("res_turn", 64'(turn), 64'(e.turn));
                    check("res_winner", 64'(winner), 64'(e.winner));
                    check("res_over", 64'(game_over), 64'(e.over));
                end
            end
            if (sbq.size() > 0 && sbq[0].due < ncount) begin
                fail($sformatf("expected response due at %0d never seen", sbq[0].due));
                void'(sbq.pop_front());
            end
            prev_busy = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic offer(int r, int c);
        exp_t e;
        bit   legal;
        move_valid = 1'b1;
        move_row   = RW'(r);
        move_col   = RW'(c);
        @(posedge clk);
        legal = (r < N) && (c < N);
        if (legal) legal = (mb[r][c] == 0);
        if (legal) begin
            mb[r][c] = int'(m_turn) + 1;
            m_count++;
            if (has_line(int'(m_turn) + 1)) begin
                m_winner = int'(m_turn) + 1;
                m_over   = 1'b1;
            end else if (m_count == N * N) begin
                m_winner = 3;
                m_over   = 1'b1;
            end else begin
                m_turn = ~m_turn;
            end
            e = '{is_err: 1'b0, board: model_bits(), turn: m_turn,
                  winner: 2'(m_winner), over: m_over, due: ncount + 5};
            sbq.push_back(e);
            #1;
            // Keep offering junk while the check runs; it must be ignored.
            repeat (4) begin
                move_row = RW'($urandom_range(0, 7));
                move_col = RW'($urandom_range(0, 7));
                @(posedge clk);
                #1;
            end
            move_valid = 1'b0;
        end else begin
            e = '{is_err: 1'b1, board: model_bits(), turn: m_turn,
                  winner: 2'(m_winner), over: 1'b0, due: ncount + 1};
            sbq.push_back(e);
            #1;
            move_valid = 1'b0;
        end
    endtask

    task automatic do_new_game(bit with_move);
        new_game   = 1'b1;
        move_valid = with_move;
        move_row   = '0;
        move_col   = '0;
        @(posedge clk);
        model_clear();
        m_start = ~m_start;
        m_turn  = m_start;
        #1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        check("ng_board", 64'(board), 64'(model_bits()));
        check("ng_turn", 64'(turn), 64'(m_turn));
        check("ng_winner", 64'(winner), 64'(0));
        check("ng_ready", 64'(move_ready), 64'(1));
    endtask

    task automatic new_game_x_first();
        do_new_game(1'b0);
        if (m_turn) do_new_game(1'b0);
    endtask

    task automatic offer_when_over();
        repeat (3) begin
            move_valid = 1'b1;
            move_row   = RW'($urandom_range(0, 7));
            move_col   = RW'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        move_valid = 1'b0;
        @(posedge clk);
        #1;
        check("over_board", 64'(board), 64'(model_bits()));
        check("over_flag", 64'(game_over), 64'(1));
        check("over_ready", 64'(move_ready), 64'(0));
        check("over_winner", 64'(winner), 64'(m_winner));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int xs[$];
        int os[$];
        int em[$];
        rst_n      = 1'b0;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_row   = '0;
        move_col   = '0;
        m_start    = 1'b0;
        m_turn     = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_board", 64'(board), 64'(0));
        check("rst_turn", 64'(turn), 64'(0));
        check("rst_winner", 64'(winner), 64'(0));
        check("rst_ready", 64'(move_ready), 64'(1));
        check("rst_over", 64'(game_over), 64'(0));
        check("rst_err", 64'(move_err), 64'(0));

        // Illegal offers: occupied cell and off-board coordinates.
        offer(0, 0);
        offer(0, 0);
        offer(5, 1);
        offer(1, 7);
        offer(7, 7);
        offer(1, 1);

        // Alternating start player and new_game beating a simultaneous move.
        do_new_game(1'b1);
        do_new_game(1'b1);

        // Anti-diagonal for X filled outside-in, completed by the middle cell.
        new_game_x_first();
        offer(3, 0); offer(4, 4); offer(0, 3); offer(4, 3);
        offer(2, 1); offer(0, 0); offer(1, 2);
        offer_when_over();

        // Three in a row is not enough when K=4.
        new_game_x_first();
        offer(2, 0); offer(4, 0); offer(2, 1); offer(4, 1);
        offer(2, 2); offer(0, 4); offer(2, 3);
        offer_when_over();

        // Full board with no line of even 3: X where (r+2c) mod 4 is 0 or 1.
        new_game_x_first();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (((r + 2 * c) % 4) < 2) xs.push_back(r * N + c);
                else os.push_back(r * N + c);
        for (int i = 0; i < N * N; i++) begin
            if (i % 2 == 0) offer(xs[i/2] / N, xs[i/2] % N);
            else            offer(os[i/2] / N, os[i/2] % N);
        end
        offer_when_over();

        // Reset in the middle of a check.
        do_new_game(1'b0);
        move_valid = 1'b1;
        move_row   = 3'd2;
        move_col   = 3'd2;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_board", 64'(board), 64'(0));
        check("arst_ready", 64'(move_ready), 64'(1));
        check("arst_turn", 64'(turn), 64'(0));
        @(posedge clk);
        #1;
        check("arst_err", 64'(move_err), 64'(0));
        rst_n   = 1'b1;
        m_start = 1'b0;
        m_turn  = 1'b0;
        model_clear();

        // Random games with occasional junk offers and abandoned games.
        for (int g = 0; g < 25; g++) begin
            do_new_game($urandom_range(0, 3) == 0);
            for (int mv = 0; mv < 60 && !m_over; mv++) begin
                if ($urandom_range(0, 49) == 0) break;
                if ($urandom_range(0, 6) == 0) begin
                    offer($urandom_range(0, 7), $urandom_range(0, 7));
                end else begin
                    em.delete();
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++)
                            if (mb[r][c] == 0) em.push_back(r * N + c);
                    begin
                        int p;
                        p = em[$urandom_range(0, em.size() - 1)];
                        offer(p / N, p % N);
                    end
                end
            end
            if (m_over) offer_when_over();
        end

        repeat (8) @(posedge clk);
        #1;
        if (sbq.size() != 0) fail($sformatf("%0d expected responses never seen", sbq.size()));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
